// File: rtl/alu_mem_datapath_pkg.sv
// Shared definitions for the ALU-plus-memory datapath: default widths, opcodes, FSM states.
package alu_mem_datapath_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StExec = 3'd3,
    StWb   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_mem_datapath_alu_core.sv
// Combinational ALU: eight ops on two DW-bit operands, with carry and signed-overflow flags.
module alu_core
  import alu_mem_datapath_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          carry,
  output logic          ovf
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        y     = sum[DW-1:0];
        carry = sum[DW];
        ovf   = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        y     = diff[DW-1:0];
        // Borrow out of the extended subtraction is the inverse of "no-borrow".
        carry = ~diff[DW];
        ovf   = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: y = a << b[3:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mem_datapath.sv
// Command datapath: read two RAM operands, run one ALU op, write the result back, report flags.
module alu_mem_datapath
  import alu_mem_datapath_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_d,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          ovf
);

  logic [DW-1:0] mem [2**AW];

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_a_q, addr_b_q, addr_d_q;
  logic [DW-1:0] a_q, rd_q, dbg_q;
  logic [DW-1:0] result_q;
  logic          zero_q, carry_q, ovf_q;

  logic          capture, ld_write, wb_write, we;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] alu_y;
  logic          alu_c, alu_v;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRdA;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign capture  = (state_q == StIdle) && start;
  assign ld_write = (state_q == StIdle) && ld_en;
  assign wb_write = (state_q == StWb);
  assign we       = ld_write || wb_write;
  assign wr_addr  = wb_write ? addr_d_q : ld_addr;
  assign wr_data  = wb_write ? result_q : ld_data;
  assign rd_addr  = (state_q == StRdA) ? addr_a_q : addr_b_q;

  // RAM is deliberately not reset; both read ports see pre-write data on a same-edge write.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  alu_core #(
    .DW(DW)
  ) u_alu_core (
    .a    (a_q),
    .b    (rd_q),
    .op   (op_q),
    .y    (alu_y),
    .carry(alu_c),
    .ovf  (alu_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_d_q <= '0;
      a_q      <= '0;
      dbg_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dbg_q   <= mem[dbg_addr];
      if (capture) begin
        op_q     <= op;
        addr_a_q <= addr_a;
        addr_b_q <= addr_b;
        addr_d_q <= addr_d;
      end
      if (state_q == StRdB) a_q <= rd_q;
      if (state_q == StExec) begin
        result_q <= alu_y;
        zero_q   <= (alu_y == '0);
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
      end
    end
  end

  assign dbg_data = dbg_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StWb);
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Scoreboard bench: commands push expected results; a monitor checks them on each done pulse.
module tb_alu_mem_datapath;
  import alu_mem_datapath_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          z;
    logic          c;
    logic          v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [AW-1:0] addr_a = '0, addr_b = '0, addr_d = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          busy, done, zero, carry, ovf;
  logic [DW-1:0] result;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   dones_seen = 0;

  alu_mem_datapath #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .addr_d  (addr_d),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic dbg_check(input string name, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp);
    dbg_addr = a;
    tick();
    checks++;
    if (dbg_data !== exp) begin
      failures++;
      $display("FAIL %s: dbg_data=%h required=%h", name, dbg_data, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s: busy still high after %0d cycles", name, n);
    end
  endtask

  task automatic cmd(input string name, input logic [2:0] o, input logic [AW-1:0] a,
                     input logic [AW-1:0] b, input logic [AW-1:0] d,
                     input logic [DW-1:0] r, input logic z, input logic c, input logic v);
    int n;
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v;
    sb.push_back(e);
    start = 1'b1; op = o; addr_a = a; addr_b = b; addr_d = d;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL %s latency: done after %0d edges required 3", name, n);
    end
    wait_idle(name);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && done) begin
            dones_seen++;
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL unexpected_done: result=%h with no command pending", result);
            end else begin
              e = sb.pop_front();
              if ({result, zero, carry, ovf} !== e) begin
                failures++;
                $display("FAIL done_flags: result=%h z=%b c=%b v=%b required %h z=%b c=%b v=%b",
                         result, zero, carry, ovf, e.res, e.z, e.c, e.v);
              end
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    #12;
    checks++;
    if ({busy, done, result, zero, carry, ovf, dbg_data} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b result=%h flags=%b%b%b dbg=%h required all 0",
               busy, done, result, zero, carry, ovf, dbg_data);
    end
    rst_n = 1'b1;
    tick();

    load(8'h01, 16'h7FFF);
    load(8'h02, 16'h0001);
    load(8'h04, 16'h0005);
    load(8'h05, 16'h0005);
    load(8'h06, 16'h0001);
    load(8'h07, 16'h0002);
    load(8'h08, 16'hFFFF);
    load(8'h09, 16'h0003);
    load(8'h0A, 16'h0004);
    load(8'h0B, 16'h0000);
    load(8'h20, 16'h1234);
    load(8'h40, 16'h0BAD);

    cmd("add_ovf", OP_ADD, 8'h01, 8'h02, 8'h03, 16'h8000, 1'b0, 1'b0, 1'b1);
    dbg_check("dbg_add", 8'h03, 16'h8000);
    cmd("sub_zero", OP_SUB, 8'h04, 8'h05, 8'h30, 16'h0000, 1'b1, 1'b1, 1'b0);
    cmd("sub_borrow", OP_SUB, 8'h06, 8'h07, 8'h31, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cmd("slt", OP_SLT, 8'h08, 8'h02, 8'h32, 16'h0001, 1'b0, 1'b0, 1'b0);
    cmd("sll", OP_SLL, 8'h09, 8'h0A, 8'h33, 16'h0030, 1'b0, 1'b0, 1'b0);
    cmd("nor", OP_NOR, 8'h0B, 8'h0B, 8'h34, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cmd("and", OP_AND, 8'h01, 8'h02, 8'h35, 16'h0001, 1'b0, 1'b0, 1'b0);
    cmd("xor", OP_XOR, 8'h01, 8'h02, 8'h36, 16'h7FFE, 1'b0, 1'b0, 1'b0);
    dbg_check("dbg_sll", 8'h33, 16'h0030);

    // Load and start together: command must see the freshly loaded word
    ld_en = 1'b1; ld_addr = 8'h50; ld_data = 16'h00F0;
    cmd("ld_and_start_or", OP_OR, 8'h50, 8'h02, 8'h37, 16'h00F1, 1'b0, 1'b0, 1'b0);
    ld_en = 1'b0;
    dbg_check("dbg_ld_start", 8'h50, 16'h00F0);

    // Reset mid-RD_B: no write to 0x20, outputs cleared
    start = 1'b1; op = OP_ADD; addr_a = 8'h01; addr_b = 8'h02; addr_d = 8'h20;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, zero, carry, ovf, dbg_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_cmd: busy=%b done=%b result=%h flags=%b%b%b dbg=%h required 0",
               busy, done, result, zero, carry, ovf, dbg_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    dbg_check("reset_no_write", 8'h20, 16'h1234);

    // Start and load pulsed while busy must be ignored
    sb.push_back('{res: 16'h8000, z: 1'b0, c: 1'b0, v: 1'b1});
    start = 1'b1; op = OP_ADD; addr_a = 8'h01; addr_b = 8'h02; addr_d = 8'h38;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = OP_SUB; ld_en = 1'b1; ld_addr = 8'h40; ld_data = 16'hDEAD;
    tick();
    start = 1'b0; ld_en = 1'b0;
    wait_idle("busy_ignore");
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_relaunch: busy=%b required 0", busy);
    end
    dbg_check("busy_ld_ignored", 8'h40, 16'h0BAD);

    // Back-to-back accumulate at 0x10 with start held
    load(8'h10, 16'h0001);
    sb.push_back('{res: 16'h0002, z: 1'b0, c: 1'b0, v: 1'b0});
    sb.push_back('{res: 16'h0004, z: 1'b0, c: 1'b0, v: 1'b0});
    sb.push_back('{res: 16'h0008, z: 1'b0, c: 1'b0, v: 1'b0});
    begin
      int n;
      int d;
      n = 0;
      d = 0;
      start = 1'b1; op = OP_ADD; addr_a = 8'h10; addr_b = 8'h10; addr_d = 8'h10;
      while (d < 3 && n < 40) begin
        tick();
        n++;
        if (done) d++;
      end
      start = 1'b0;
      checks++;
      if (d != 3 || n != 14) begin
        failures++;
        $display("FAIL back_to_back: dones=%0d after %0d edges required 3 after 14", d, n);
      end
    end
    wait_idle("back_to_back");
    dbg_check("dbg_accum", 8'h10, 16'h0008);

    tick();
    checks++;
    if (sb.size() != 0 || dones_seen != 13) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d dones=%0d required 0 and 13",
               sb.size(), dones_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
